// File: rtl/npc_redirect_ctrl.sv
// npc_redirect_ctrl: next-PC redirect sequencer for the fetch stage.
// Arbitrates trap, return-from-trap and branch redirect requests. It drives
// the nPC register's load strobe and target, and its sequential-increment
// enable. Taken, non-annulled branches keep their SPARC delay slot. Traps and
// rett hold fetch in a flush window for FLUSH_CYCLES cycles.
module npc_redirect_ctrl #(
    parameter int PC_SIZE      = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,        // asynchronous, active-low
    input  logic               fetch_ready,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic               br_annul,
    input  logic [PC_SIZE-1:0] br_target,
    output logic               br_ack,
    input  logic               trap_valid,
    input  logic [7:0]         trap_tt,
    input  logic [PC_SIZE-1:0] tba,
    output logic               trap_ack,
    input  logic               rett_valid,
    input  logic [PC_SIZE-1:0] rett_target,
    output logic               rett_ack,
    output logic               mux_en,
    output logic [PC_SIZE-1:0] target,
    output logic               if_ready,
    output logic               flush,
    output logic [1:0]         state
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLOT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PC_SIZE-1:0]   pend_q, pend_d;
    logic                 mux_en_q, mux_en_d;
    logic [PC_SIZE-1:0]   target_q, target_d;
    logic                 flush_q, flush_d;

    logic                 in_flush;
    logic                 in_run;
    logic                 can_accept;
    logic [PC_SIZE-1:0]   trap_pc;

    // The encoding 3 is unused and behaves as RUN.
    assign in_flush = (state_q == ST_FLUSH);
    assign in_run   = (state_q != ST_SLOT) && !in_flush;

    // No request is accepted while a redirect is presented to the nPC. This
    // keeps mux_en a one-cycle pulse even when requests arrive back to back.
    assign can_accept = !mux_en_q;

    // Trap vector: the upper bits of the trap base, then the trap type, then a
    // 16-byte slot per vector.
    assign trap_pc = {tba[PC_SIZE-1:12], trap_tt, 4'b0000};

    // Fixed-priority acceptance: trap > rett > branch. At most one ack is set.
    assign trap_ack = trap_valid && !in_flush && can_accept;
    assign rett_ack = rett_valid && !trap_valid && in_run && can_accept;
    assign br_ack   = br_valid && !trap_valid && !rett_valid && in_run && can_accept;

    // Next-state and next-output logic for the redirect sequencer.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        mux_en_d = 1'b0;
        target_d = target_q;
        flush_d  = 1'b0;

        if (trap_ack || rett_ack) begin
            // A trap also discards any branch target latched for a delay slot.
            mux_en_d = 1'b1;
            target_d = trap_ack ? trap_pc : rett_target;
            flush_d  = 1'b1;
            state_d  = ST_FLUSH;
            cnt_d    = CNT_W'(FLUSH_CYCLES);
            pend_d   = '0;
        end else begin
            case (state_q)
                ST_SLOT: begin
                    // The delay slot issues in the first cycle that fetch is
                    // ready. The branch target loads on the next cycle.
                    if (fetch_ready) begin
                        mux_en_d = 1'b1;
                        target_d = pend_q;
                        pend_d   = '0;
                        state_d  = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        flush_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (br_ack && br_taken) begin
                        if (br_annul) begin
                            // Annulled: skip the slot and redirect right away.
                            mux_en_d = 1'b1;
                            target_d = br_target;
                            flush_d  = 1'b1;
                        end else begin
                            pend_d  = br_target;
                            state_d = ST_SLOT;
                        end
                    end
                end
            endcase
        end
    end

    // State and registered outputs. The asynchronous reset also clears any
    // pending target or flush count, so no redirect appears after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            pend_q   <= '0;
            mux_en_q <= 1'b0;
            target_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples the values from before this edge.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            mux_en_q <= mux_en_d;
            target_q <= target_d;
            flush_q  <= flush_d;
        end
    end

    assign mux_en   = mux_en_q;
    assign target   = target_q;
    assign flush    = flush_q;
    assign state    = state_q;
    // The nPC must never increment in the same cycle that it loads a redirect.
    assign if_ready = fetch_ready && !mux_en_q && !in_flush;

endmodule

// File: doc/npc_redirect_ctrl.md
Name: npc_redirect_ctrl

Overview:
- Sequences the next-PC register for the fetch stage.
- Arbitrates redirect requests from the trap unit, the return-from-trap (rett) path and the branch unit.
- Drives the nPC register's mux_en/target/if_ready inputs.
- Honours the SPARC delay slot for taken branches and flushes fetch for a programmable number of cycles after traps and rett.

Parameters:
PC_SIZE, 64, width of all PC/target buses
FLUSH_CYCLES, 2, cycles fetch is held after a trap/rett redirect (legal range >=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (reset=0 asserts)
fetch_ready  in  1  fetch stage can accept a PC this cycle
br_valid  in  1  branch resolution request; held until br_ack
br_taken  in  1  branch taken
br_annul  in  1  annul bit of the branch
br_target  in  PC_SIZE  branch target
br_ack  out  1  branch request consumed (combinational)
trap_valid  in  1  trap request; held until trap_ack
trap_tt  in  8  trap type
tba  in  PC_SIZE  trap base address
trap_ack  out  1  trap consumed (combinational)
rett_valid  in  1  return-from-trap request; held until rett_ack
rett_target  in  PC_SIZE  return PC
rett_ack  out  1  rett consumed (combinational)
mux_en  out  1  nPC load-target strobe (registered)
target  out  PC_SIZE  redirect PC (registered)
if_ready  out  1  allow nPC sequential increment
flush  out  1  kill in-flight fetch (registered)
state  out  2  FSM state, for debug

Behaviour:
- Reset (async, reset=0):
  - state=RUN, counter=0, pending target=0.
  - mux_en=0, target=0, flush=0.
  - Release is synchronous to the clk edge.
- States: RUN=0, SLOT=1, FLUSH=2 (3 unused; decodes to RUN).
- Acceptance priority, evaluated combinationally each cycle: trap > rett > branch. At most one ack is high per cycle.
- RUN:
  - trap_valid: trap_ack=1. Next cycle: mux_en=1, target={tba[PC_SIZE-1:12], trap_tt, 4'b0000}, flush=1. State goes to FLUSH, counter=FLUSH_CYCLES.
  - rett_valid (no trap): rett_ack=1. Same as the trap case, with target=rett_target.
  - br_valid, taken, !annul: br_ack=1, latch br_target, state goes to SLOT. No redirect yet; the delay slot is fetched sequentially.
  - br_valid, taken, annul: br_ack=1. Next cycle: mux_en=1, target=br_target, flush=1 for one cycle. State stays RUN.
  - br_valid, !taken: br_ack=1, no redirect, state stays RUN.
- SLOT:
  - br_ack=0 and rett_ack=0.
  - On the first cycle with fetch_ready=1 (delay slot issued): next cycle mux_en=1, target=latched target, state goes to RUN.
  - trap_valid in SLOT: trap accepted per the RUN rule. The latched branch is discarded.
- FLUSH:
  - All acks=0, flush=1, if_ready=0.
  - Counter decrements each cycle. When the counter reaches 1, state goes to RUN on the next edge.
  - Counter width is $clog2(FLUSH_CYCLES+1).
- mux_en is always a single-cycle pulse.
- if_ready = fetch_ready & !mux_en & (state!=FLUSH). This ensures the nPC never increments and redirects in the same cycle.
- Requests that are not acked must be held by the requester. The block never drops an acked request.
- Reset mid-SLOT or mid-FLUSH: pending target and counter are cleared immediately. No mux_en is emitted after release.
- PC arithmetic is done by the nPC register. This block only selects targets, with no add or wrap logic.

Test Plan:
- Reset with reset=0 mid-FLUSH -> mux_en=0, flush=0, state=RUN within the same cycle; stays there after release with no requests.
- br_valid=1, taken=1, annul=0, br_target=0x1000, fetch_ready=0 for 3 cycles then 1 -> state=SLOT for 4 cycles; mux_en pulses with target=0x1000 exactly one cycle after fetch_ready rises.
- trap_valid and br_valid asserted in the same cycle, tba=0x40000, trap_tt=0x05 -> trap_ack=1, br_ack=0; next cycle mux_en=1, target=0x40050; flush=1 and if_ready=0 for 2 cycles (FLUSH_CYCLES=2); br_ack is granted only once state returns to RUN.
- Taken annulled branch to 0x2000 -> one-cycle mux_en with target=0x2000, one-cycle flush, state stays RUN, no SLOT entry.
- Trap in SLOT with latched target 0x3000 -> trap target is issued; 0x3000 never appears on target with mux_en=1.
- rett_valid with rett_target=0x8004, fetch_ready=1 constantly -> if_ready=0 during the mux_en cycle and both FLUSH cycles, then 1.
